lsu_mem_port: RTL
=================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The core-side ports SHALL be: req_valid input 1 (request present); req_ready output 1 (request accepted when req_valid and req_ready are both high); req_write input 1 (1=store, 0=load); req_funct3 input 3 (RV32I width/sign code); req_addr input 32 (byte address); req_wdata input 32 (store data, LSB-aligned); req_rd input 5 (load destination register).
REQ-003 The memory-side ports SHALL be: mem_req output 1 (access strobe); mem_we output 1 (write enable); mem_be output 4 (byte enables); mem_addr output 32 (word address, bits[1:0]=0); mem_wdata output 32 (lane-shifted store data); mem_ack input 1 (one-cycle access-completion pulse); mem_rdata input 32 (read word, valid with mem_ack).
REQ-004 The writeback ports SHALL be: wb_valid output 1 (register write strobe); wb_addr output 5 (destination register); wb_data output 32 (extended load value); misalign_err output 1 (one-cycle fault pulse).

Function
REQ-005 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL assert req_ready only in IDLE.
REQ-006 On acceptance, the block SHALL register the address, data, funct3, rd and write flag, and SHALL go from IDLE to WAIT on the next edge.
REQ-007 In WAIT, mem_req SHALL stay high and mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable until the cycle mem_ack is high.
REQ-008 A mem_ack in WAIT SHALL move the FSM to RESP for a load and to IDLE for a store.
REQ-009 mem_ack outside WAIT SHALL be ignored.
REQ-010 In RESP, wb_valid SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-011 Minimum load latency SHALL be 3 cycles from acceptance to wb_valid with zero-wait memory; minimum store occupancy SHALL be 2 cycles.
REQ-012 Byte enables SHALL be: funct3[1:0]=00 -> 4'b0001 << addr[1:0]; 01 -> 4'b0011 << addr[1:0]; 10 -> 4'b1111.
REQ-013 mem_wdata SHALL be req_wdata byte/half replicated to its lane (byte -> {4{b}}, half -> {2{h}}).
REQ-014 A load SHALL select the lane from mem_rdata by the registered addr[1:0].
REQ-015 funct3 000/001 SHALL sign-extend a loaded byte/halfword; 100/101 SHALL zero-extend; 010 SHALL pass the word through.
REQ-016 The loaded word SHALL be captured in a register on mem_ack, and wb_data SHALL come from that register.
REQ-017 Misalignment SHALL be defined as a halfword access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-018 A misaligned request SHALL still be accepted, SHALL issue no mem_req, SHALL pulse misalign_err in the cycle after acceptance, and SHALL leave the FSM in IDLE.
REQ-019 funct3 values 011, 110 and 111 SHALL be treated as misaligned (error path).
REQ-020 A load with rd=0 SHALL complete the memory access but SHALL keep wb_valid low in RESP.
REQ-021 wb_addr and wb_data SHALL hold their last values when wb_valid is low.
REQ-022 Back-to-back requests SHALL be accepted in the first IDLE cycle after the prior completion, with no extra bubble.

Reset
REQ-023 rst high at a clock edge SHALL force IDLE in any state and SHALL clear all registered request fields.
REQ-024 While rst is high, and in the cycle after it, req_ready SHALL be 0; outputs SHALL reset to mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_addr=0, wb_data=0, misalign_err=0.
REQ-025 Reset during WAIT SHALL abandon the access, and any later mem_ack for it SHALL be ignored.
REQ-026 req_ready SHALL rise in the second cycle after rst deasserts.

Structure
REQ-027 A shared package lsu_pkg SHALL hold the funct3 width codes (LB, LH, LW, LBU, LHU), the FSM state enum and the byte-enable function.
REQ-028 Load lane extraction and extension SHALL be a separate combinational sub-module, load_extend (inputs: word, offset, funct3; output: 32-bit value).

Verification
REQ-029 Test: LW addr=0x100, mem_rdata=0xDEADBEEF with ack after 0 waits -> mem_be=1111, mem_addr=0x100, wb_data=0xDEADBEEF, wb_valid 3 cycles after acceptance.
REQ-030 Test: LB addr=0x103, mem_rdata=0x80FF0000 -> mem_be=1000, wb_data=0xFFFFFF80; LBU at the same address -> wb_data=0x00000080.
REQ-031 Test: SH addr=0x202, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, no wb_valid.
REQ-032 Test: LW addr=0x101 -> misalign_err pulse, mem_req stays 0, req_ready high the next cycle.
REQ-033 Test: LH rd=0 with mem_ack delayed 5 cycles -> mem_req held for 6 cycles with stable outputs, no wb_valid.
REQ-034 Test: rst asserted in WAIT, then a stray mem_ack -> no wb_valid, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory port: RV32I width codes,
// FSM states and the lane helpers used on both the request and response paths.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      LB, LBU: byte_enable = 4'b0001 << offset;
      LH, LHU: byte_enable = 4'b0011 << offset;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  // Reserved width codes are folded into the misaligned/error path.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      LB, LBU: is_misaligned = 1'b0;
      LH, LHU: is_misaligned = offset[0];
      LW:      is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      LB, LBU: store_lanes = {4{data[7:0]}};
      LH, LHU: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane selection and sign/zero extension for a read word.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      value = {{24{lane_b[7]}}, lane_b};
      LH:      value = {{16{lane_h[15]}}, lane_h};
      LBU:     value = {24'd0, lane_b};
      LHU:     value = {16'd0, lane_h};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port between the core and a word-wide memory
// with an ack handshake; loads return an extended value on the writeback port.
module lsu_mem_port
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  lsu_state_e  state, state_next;
  logic        init_done;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q, wb_addr_q;
  logic        write_q;
  logic [3:0]  be_q;
  logic        err_q;
  logic        accept, req_misaligned, load_capture;
  logic [31:0] load_value;

  assign req_misaligned = is_misaligned(req_funct3, req_addr[1:0]);
  assign accept         = req_valid && req_ready;
  assign load_capture   = (state == WAIT) && mem_ack && !write_q && (rd_q != 5'd0);

  load_extend u_load_extend (
    .word   (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .value  (load_value)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // init_done keeps req_ready low for the first cycle after reset releases.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    wb_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = init_done && !rst;
        if (req_valid && req_ready && !req_misaligned) state_next = WAIT;
      end
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = write_q ? IDLE : RESP;
      end
      RESP: begin
        wb_valid   = (rd_q != 5'd0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The extended value and its register are captured together so the
  // writeback outputs hold steady across later requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      write_q   <= 1'b0;
      be_q      <= '0;
      data_q    <= '0;
      wb_addr_q <= '0;
    end else begin
      init_done <= 1'b1;
      err_q     <= accept && req_misaligned;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= store_lanes(req_funct3, req_wdata);
        funct3_q <= req_funct3;
        rd_q     <= req_rd;
        write_q  <= req_write;
        be_q     <= byte_enable(req_funct3, req_addr[1:0]);
      end
      if (load_capture) begin
        data_q    <= load_value;
        wb_addr_q <= rd_q;
      end
    end
  end

  assign mem_we       = (state == WAIT) && write_q;
  assign mem_be       = (state == WAIT) ? be_q : 4'b0000;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wdata    = wdata_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = data_q;
  assign misalign_err = err_q;

endmodule
